// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Function : Sequential double-dabble binary-to-BCD converter, one bit per
//            clock, with overflow flag and leading-zero blanking mask.
// Revision : 1.0
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = 6;
    localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_scr_q, ovf_scr_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic [DIGITS-1:0] lz_q, lz_d;

    logic [BW-1:0]     w_adj;
    logic [BW-1:0]     w_scr_sh;
    logic [WIDTH-1:0]  w_bin_sh;
    logic              w_ovf_sh;
    logic [DIGITS-1:0] w_lz;
    logic              w_allz;

    // One double-dabble iteration plus the blanking mask of its result, so the
    // final iteration can load the output registers directly.
    always_comb begin
        w_adj = scr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
        {w_scr_sh, w_bin_sh} = {w_adj, bin_q} << 1;
        w_ovf_sh = ovf_scr_q | w_adj[BW-1];
        w_lz     = '0;
        w_allz   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_allz  = w_allz & (w_scr_sh[4*k +: 4] == 4'd0);
            w_lz[k] = w_allz & ~w_ovf_sh;
        end
    end

    always_comb begin
        state_d   = state_q;
        scr_d     = scr_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        ovf_scr_d = ovf_scr_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        lz_d      = lz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    bin_d     = bin;
                    scr_d     = '0;
                    ovf_scr_d = 1'b0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SHIFT: begin
                scr_d     = w_scr_sh;
                bin_d     = w_bin_sh;
                ovf_scr_d = w_ovf_sh;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    bcd_d   = w_scr_sh;
                    ovf_d   = w_ovf_sh;
                    lz_d    = w_lz;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            scr_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            ovf_scr_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            lz_q      <= LZ_RST;
        end else begin
            state_q   <= state_d;
            scr_q     <= scr_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            ovf_scr_q <= ovf_scr_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            lz_q      <= lz_d;
        end
    end

    assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign lz_mask  = lz_q;

endmodule
`default_nettype wire
